// File: rtl/router_pkg.sv
// Shared router definitions: default byte width, the reserved destination address
// and the router_fsm state encoding used by the strobes that drive router_reg.
package router_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    WAIT_TILL_EMPTY    = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } router_state_e;

  function automatic logic addr_is_valid(input logic [1:0] addr);
    return (addr != ADDR_INVALID);
  endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR accumulator: clear has priority over enable; result is registered.
module router_parity_acc
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] parity
);

  logic [DATA_WIDTH-1:0] parity_r;

  // Accumulate the XOR of every enabled byte since the last clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      parity_r <= '0;
    end else if (clear) begin
      parity_r <= '0;
    end else if (enable) begin
      parity_r <= parity_r ^ din;
    end else begin
      parity_r <= parity_r;
    end
  end

  assign parity = parity_r;

endmodule

// File: rtl/router_reg.sv
// Router datapath register block: header/hold capture, output byte, parity check.
// Optional error counter output err_cnt is enabled by defining ROUTER_REG_ERR_CNT_EN.
module router_reg
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_done,
  output logic                  low_packet_valid,
  output logic                  err
`ifdef ROUTER_REG_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  logic [DATA_WIDTH-1:0] header_r;
  logic [DATA_WIDTH-1:0] hold_r;
  logic [DATA_WIDTH-1:0] dout_r;
  logic [DATA_WIDTH-1:0] pkt_parity_r;
  logic                  lpv_r;
  logic                  pd_r;
  logic                  pd_prev_r;
  logic                  err_r;

  logic                  det_s;
  logic                  lfd_s;
  logic                  ld_s;
  logic                  laf_s;
  logic                  acc_clear_s;
  logic                  acc_en_s;
  logic [DATA_WIDTH-1:0] acc_din_s;
  logic [DATA_WIDTH-1:0] int_parity_s;
  logic                  err_check_s;
  logic                  mismatch_s;

  // Resolve illegal overlapping strobes by fixed priority.
  always_comb begin
    det_s = detect_add;
    lfd_s = lfd_state & ~detect_add;
    ld_s  = ld_state & ~detect_add & ~lfd_state;
    laf_s = laf_state & ~detect_add & ~lfd_state & ~ld_state;
  end

  // Select the byte folded into the internal parity this cycle.
  always_comb begin
    acc_clear_s = 1'b0;
    acc_en_s    = 1'b0;
    acc_din_s   = '0;
    if (det_s) begin
      acc_clear_s = 1'b1;
    end else if (lfd_s) begin
      acc_en_s  = 1'b1;
      acc_din_s = header_r;
    end else if (ld_s) begin
      acc_en_s  = pkt_valid & ~full_state & ~fifo_full;
      acc_din_s = data_in;
    end else if (laf_s) begin
      acc_en_s  = ~lpv_r;
      acc_din_s = hold_r;
    end else begin
      acc_en_s  = 1'b0;
    end
  end

  router_parity_acc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_acc (
    .clock  (clock),
    .resetn (resetn),
    .clear  (acc_clear_s),
    .enable (acc_en_s),
    .din    (acc_din_s),
    .parity (int_parity_s)
  );

  assign err_check_s = pd_r & ~pd_prev_r;
  assign mismatch_s  = (int_parity_s != pkt_parity_r);

  // Header capture; the reserved address leaves the previous header in place.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      header_r <= '0;
    end else if (det_s && pkt_valid && addr_is_valid(data_in[1:0])) begin
      header_r <= data_in;
    end else begin
      header_r <= header_r;
    end
  end

  // Output byte and the byte parked while the output FIFO is full.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dout_r <= '0;
      hold_r <= '0;
    end else if (lfd_s) begin
      dout_r <= header_r;
    end else if (ld_s && !fifo_full) begin
      dout_r <= data_in;
    end else if (ld_s && fifo_full) begin
      hold_r <= data_in;
    end else if (laf_s) begin
      dout_r <= hold_r;
    end else begin
      dout_r <= dout_r;
      hold_r <= hold_r;
    end
  end

  // Packet parity byte and the end-of-packet flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_parity_r <= '0;
      lpv_r        <= 1'b0;
    end else if (det_s) begin
      pkt_parity_r <= '0;
    end else if (ld_s && !pkt_valid) begin
      pkt_parity_r <= data_in;
      lpv_r        <= 1'b1;
    end else if (rst_int_reg) begin
      lpv_r        <= 1'b0;
    end else begin
      pkt_parity_r <= pkt_parity_r;
      lpv_r        <= lpv_r;
    end
  end

  // parity_done, its delayed copy for edge detection, and the error flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pd_r      <= 1'b0;
      pd_prev_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      pd_prev_r <= pd_r;
      if (det_s) begin
        pd_r  <= 1'b0;
        err_r <= 1'b0;
      end else begin
        if ((ld_s && !fifo_full && !pkt_valid) || (laf_s && lpv_r && !pd_r)) begin
          pd_r <= 1'b1;
        end else begin
          pd_r <= pd_r;
        end
        if (err_check_s) begin
          err_r <= mismatch_s;
        end else begin
          err_r <= err_r;
        end
      end
    end
  end

`ifdef ROUTER_REG_ERR_CNT_EN
  logic [7:0] err_cnt_r;
  logic       err_rise_s;

  assign err_rise_s = ~det_s & err_check_s & mismatch_s & ~err_r;

  // Saturating count of err rising edges; only resetn clears it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err_cnt_r <= 8'd0;
    end else if (err_rise_s && (err_cnt_r != 8'd255)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`endif

  assign dout             = dout_r;
  assign parity_done      = pd_r;
  assign low_packet_valid = lpv_r;
  assign err              = err_r;

endmodule

// File: tb/tb_router_reg.sv
// Directed testbench for router_reg; err_cnt checks run when ROUTER_REG_ERR_CNT_EN is defined.
module tb_router_reg;

  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic [7:0] dout;
  logic       parity_done;
  logic       low_packet_valid;
  logic       err;
`ifdef ROUTER_REG_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int checks;
  int errors;

  router_reg #(.DATA_WIDTH(8)) dut (
    .clock            (clock),
    .resetn           (resetn),
    .pkt_valid        (pkt_valid),
    .data_in          (data_in),
    .fifo_full        (fifo_full),
    .detect_add       (detect_add),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .rst_int_reg      (rst_int_reg),
    .dout             (dout),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid),
    .err              (err)
`ifdef ROUTER_REG_ERR_CNT_EN
    ,
    .err_cnt          (err_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of strobes, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic da, input logic lfd, input logic ld, input logic laf,
                     input logic pv, input logic ff, input logic [7:0] d);
    detect_add  = da;
    lfd_state   = lfd;
    ld_state    = ld;
    laf_state   = laf;
    pkt_valid   = pv;
    fifo_full   = ff;
    data_in     = d;
    full_state  = 1'b0;
    rst_int_reg = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_int();
    detect_add = 1'b0; lfd_state = 1'b0; ld_state = 1'b0; laf_state = 1'b0;
    pkt_valid = 1'b0; fifo_full = 1'b0; full_state = 1'b0; rst_int_reg = 1'b1;
    @(posedge clock);
    #1;
    rst_int_reg = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle();
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
    checks++; if (parity_done !== 1'b0) begin errors++; $display("FAIL reset_pd got %b exp 0", parity_done); end
    checks++; if (low_packet_valid !== 1'b0) begin errors++; $display("FAIL reset_lpv got %b exp 0", low_packet_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
`ifdef ROUTER_REG_ERR_CNT_EN
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", err_cnt); end
`endif
    resetn = 1'b1;
    idle();
  endtask

  task automatic test_good_packet();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
    checks++; if (parity_done !== 1'b0) begin errors++; $display("FAIL good_pd0 got %b exp 0", parity_done); end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
    checks++; if (dout !== 8'h05) begin errors++; $display("FAIL good_hdr got %h exp 05", dout); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
    checks++; if (dout !== 8'h11) begin errors++; $display("FAIL good_p0 got %h exp 11", dout); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
    checks++; if (dout !== 8'h22) begin errors++; $display("FAIL good_p1 got %h exp 22", dout); end
    checks++; if (parity_done !== 1'b0) begin errors++; $display("FAIL good_pd1 got %b exp 0", parity_done); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h36);
    checks++; if (parity_done !== 1'b1) begin errors++; $display("FAIL good_pd2 got %b exp 1", parity_done); end
    checks++; if (low_packet_valid !== 1'b1) begin errors++; $display("FAIL good_lpv got %b exp 1", low_packet_valid); end
    checks++; if (dout !== 8'h36) begin errors++; $display("FAIL good_par got %h exp 36", dout); end
    idle();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL good_err got %b exp 0", err); end
    clear_int();
    checks++; if (low_packet_valid !== 1'b0) begin errors++; $display("FAIL good_lpv_clr got %b exp 0", low_packet_valid); end
    checks++; if (parity_done !== 1'b1) begin errors++; $display("FAIL good_pd_hold got %b exp 1", parity_done); end
  endtask

  task automatic test_bad_parity();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h37);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_err_early got %b exp 0", err); end
    idle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err got %b exp 1", err); end
    idle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err_hold got %b exp 1", err); end
    clear_int();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_err_clr got %b exp 0", err); end
    checks++; if (parity_done !== 1'b0) begin errors++; $display("FAIL bad_pd_clr got %b exp 0", parity_done); end
  endtask

  task automatic test_fifo_full_stall();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hAA);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hAA);
    checks++; if (dout !== 8'h05) begin errors++; $display("FAIL stall_hold got %h exp 05", dout); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    checks++; if (dout !== 8'hAA) begin errors++; $display("FAIL stall_laf got %h exp AA", dout); end
    checks++; if (parity_done !== 1'b0) begin errors++; $display("FAIL stall_pd0 got %b exp 0", parity_done); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
    checks++; if (dout !== 8'h11) begin errors++; $display("FAIL stall_p1 got %h exp 11", dout); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hBE);
    checks++; if (parity_done !== 1'b1) begin errors++; $display("FAIL stall_pd got %b exp 1", parity_done); end
    idle();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL stall_err got %b exp 0", err); end
    clear_int();
  endtask

  task automatic test_parity_via_laf();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h14);
    checks++; if (dout !== 8'h11) begin errors++; $display("FAIL laf_hold got %h exp 11", dout); end
    checks++; if (parity_done !== 1'b0) begin errors++; $display("FAIL laf_pd0 got %b exp 0", parity_done); end
    checks++; if (low_packet_valid !== 1'b1) begin errors++; $display("FAIL laf_lpv got %b exp 1", low_packet_valid); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (dout !== 8'h14) begin errors++; $display("FAIL laf_dout got %h exp 14", dout); end
    checks++; if (parity_done !== 1'b1) begin errors++; $display("FAIL laf_pd got %b exp 1", parity_done); end
    idle();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL laf_err got %b exp 0", err); end
    clear_int();
  endtask

  task automatic test_invalid_addr();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0A);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55);
    checks++; if (dout !== 8'h0A) begin errors++; $display("FAIL inv_hdr0 got %h exp 0A", dout); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55);
    checks++; if (dout !== 8'h0A) begin errors++; $display("FAIL inv_hdr_kept got %h exp 0A", dout); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h06);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55);
    checks++; if (dout !== 8'h0A) begin errors++; $display("FAIL inv_nopv got %h exp 0A", dout); end
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h37);
    idle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ar_pre_err got %b exp 1", err); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL ar_dout got %h exp 00", dout); end
    checks++; if (parity_done !== 1'b0) begin errors++; $display("FAIL ar_pd got %b exp 0", parity_done); end
    checks++; if (low_packet_valid !== 1'b0) begin errors++; $display("FAIL ar_lpv got %b exp 0", low_packet_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ar_err got %b exp 0", err); end
    idle();
    resetn = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h77);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0F);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL ar_hdr_zero got %h exp 00", dout); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
    checks++; if (dout !== 8'h11) begin errors++; $display("FAIL ar_mid_pre got %h exp 11", dout); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL ar_mid_dout got %h exp 00", dout); end
    idle();
    resetn = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h36);
    idle();
    checks++; if (parity_done !== 1'b1) begin errors++; $display("FAIL ar_clean_pd got %b exp 1", parity_done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ar_clean_err got %b exp 0", err); end
    clear_int();
  endtask

`ifdef ROUTER_REG_ERR_CNT_EN
  task automatic bad_pkt();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle();
    clear_int();
  endtask

  task automatic test_err_cnt();
    resetn = 1'b0;
    idle();
    resetn = 1'b1;
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL cnt_reset got %0d exp 0", err_cnt); end
    bad_pkt();
    idle();
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL cnt_one got %0d exp 1", err_cnt); end
    for (int i = 0; i < 256; i++) begin
      bad_pkt();
    end
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL cnt_sat got %0d exp 255", err_cnt); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 1'b0; detect_add = 1'b0;
    lfd_state = 1'b0; ld_state = 1'b0; laf_state = 1'b0; full_state = 1'b0; rst_int_reg = 1'b0;
    test_reset();
    test_good_packet();
    test_bad_parity();
    clear_int();
    test_fifo_full_stall();
    test_parity_via_laf();
    test_invalid_addr();
    test_async_reset();
`ifdef ROUTER_REG_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
